// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge (master) and one register-file completer (slave).
// Carries select, strobes, address/data and the completer's response signals.
interface apb_slave_regfile_if;
   logic [2:0]  pselx;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output pselx, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  pselx, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer holding a DEPTH x 32-bit register file with registered responses.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states on every transfer.
module apb_slave_regfile #(
   parameter int unsigned SLV_IDX     = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                hclk,
   input  logic                hreset,
   apb_slave_regfile_if.slave  apb,
   output logic [15:0]         xfer_cnt,
   output logic                prot_err
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two in 2..256");
   end
   if (WAIT_CYCLES > 15 || SLV_IDX > 2) begin : g_bad_param
      $error("WAIT_CYCLES must be 0..15 and SLV_IDX 0..2");
   end

   typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              hit_q, hit_d;
   logic              write_q, write_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       prdata_q, prdata_d;
   logic              pready_q, pready_d;
   logic              pslverr_q, pslverr_d;
   logic [15:0]       xfer_cnt_q, xfer_cnt_d;
   logic              prot_err_q, prot_err_d;
   logic [31:0]       regs_q [DEPTH];
`ifdef APB_WAIT_STATE_EN
   logic [3:0]        cnt_q, cnt_d;
`endif

   logic              sel;
   logic [31:0]       off;
   logic              hit;
   logic [IdxW-1:0]   idx;
   logic              commit;
   logic              rsp_go;
   logic              rsp_hit;
   logic              rsp_write;
   logic [IdxW-1:0]   rsp_idx;
   logic              unused_pselx;

   assign sel          = apb.pselx[SLV_IDX];
   assign unused_pselx = ^apb.pselx;

   // Offset wraps modulo 2^32, so addresses below BASE_ADDR decode as misses.
   assign off = apb.paddr - BASE_ADDR;
   assign hit = (apb.paddr[1:0] == 2'b00) && (off < 32'(4 * DEPTH));
   assign idx = off[IdxW+1:2];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hit_d      = hit_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      prdata_d   = prdata_q;
      pready_d   = 1'b0;
      pslverr_d  = 1'b0;
      xfer_cnt_d = xfer_cnt_q;
      prot_err_d = prot_err_q;
      commit     = 1'b0;
      rsp_go     = 1'b0;
      rsp_hit    = hit_q;
      rsp_write  = write_q;
      rsp_idx    = idx_q;
`ifdef APB_WAIT_STATE_EN
      cnt_d      = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (sel && !apb.penable) begin
               idx_d     = idx;
               hit_d     = hit;
               write_d   = apb.pwrite;
               wdata_d   = apb.pwdata;
               rsp_hit   = hit;
               rsp_write = apb.pwrite;
               rsp_idx   = idx;
`ifdef APB_WAIT_STATE_EN
               if (WAIT_CYCLES > 0) begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES);
               end else begin
                  state_d = StReady;
                  rsp_go  = 1'b1;
               end
`else
               state_d = StReady;
               rsp_go  = 1'b1;
`endif
            end else if (sel && apb.penable) begin
               prot_err_d = 1'b1;
            end
         end
`ifdef APB_WAIT_STATE_EN
         StWait: begin
            if (!sel) begin
               state_d = StIdle;
            end else if (cnt_q == 4'd1) begin
               state_d = StReady;
               rsp_go  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         StReady: begin
            state_d = StIdle;
            if (sel && apb.penable) begin
               commit     = write_q && hit_q;
               xfer_cnt_d = xfer_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Response is computed one edge early so pready/prdata come straight from flops.
      if (rsp_go) begin
         pready_d = 1'b1;
         if (!rsp_hit) begin
            prdata_d  = '0;
            pslverr_d = 1'b1;
         end else if (!rsp_write) begin
            prdata_d = regs_q[rsp_idx];
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         hit_q      <= 1'b0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         prdata_q   <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         xfer_cnt_q <= '0;
         prot_err_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hit_q      <= hit_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         prdata_q   <= prdata_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         xfer_cnt_q <= xfer_cnt_d;
         prot_err_q <= prot_err_d;
         if (commit) begin
            regs_q[idx_q] <= wdata_q;
         end
      end
   end

`ifdef APB_WAIT_STATE_EN
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign apb.prdata  = prdata_q;
   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign xfer_cnt    = xfer_cnt_q;
   assign prot_err    = prot_err_q;

endmodule
